// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory access size encodings, load/store unit
// state encoding and the data returned on a bus error.
package cpu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'h0000_0000;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit: store data replication with
// byte-enable generation, and load data extraction with sign/zero extension.
module lsu_lane_align
    import cpu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_signed,
    input  logic [31:0] ld_data,
    output logic [31:0] ld_ext
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Size encoding 11 falls through to the word case.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            SZ_BYTE: begin
                st_be    = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = ld_data[7:0];
            2'd1:    ld_byte = ld_data[15:8];
            2'd2:    ld_byte = ld_data[23:16];
            default: ld_byte = ld_data[31:24];
        endcase
        ld_half = ld_off[1] ? ld_data[31:16] : ld_data[15:0];
        ld_ext  = ld_data;
        case (ld_size)
            SZ_BYTE: ld_ext = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: turns MemRead/MemWrite into a handshaked bus
// transaction and stalls the core until it completes. Optional misaligned
// access trapping is enabled with the LSU_MISALIGN_TRAP_EN macro.
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic        Stall,
    output logic [31:0] DataOut,
    output logic        BusErr,
    output logic        MisAlign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t        state, next_state;
    logic [CNT_W-1:0]  tout_cnt;
    logic [1:0]        lat_size;
    logic [1:0]        lat_off;
    logic              lat_signed;
    logic              accept;
    logic              timeout;
    logic              trap;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic [31:0]       ld_ext;

    lsu_lane_align u_align (
        .st_size   (MemSize),
        .st_off    (ALUResult[1:0]),
        .st_data   (WriteData),
        .st_be     (st_be),
        .st_wdata  (st_wdata),
        .ld_size   (lat_size),
        .ld_off    (lat_off),
        .ld_signed (lat_signed),
        .ld_data   (bus_rdata),
        .ld_ext    (ld_ext)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    logic mis_q;

    assign misaligned = ((MemSize == SZ_HALF) && ALUResult[0]) ||
                        (MemSize[1] && (ALUResult[1:0] != 2'b00));
    assign trap       = misaligned;
    assign MisAlign   = mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      mis_q <= 1'b0;
        else if (accept) mis_q <= trap;
    end
`else
    assign trap     = 1'b0;
    assign MisAlign = 1'b0;
`endif

    // Requests seen in DONE still belong to the instruction just served.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    accept     = 1'b1;
                    next_state = trap ? DONE : REQ;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    next_state = DONE;
                end else if (tout_cnt == CNT_LAST) begin
                    timeout    = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign Stall   = ((state == IDLE) && (MemRead || MemWrite)) || (state == REQ);
    assign bus_req = (state == REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tout_cnt   <= '0;
            DataOut    <= '0;
            BusErr     <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
            lat_size   <= SZ_BYTE;
            lat_off    <= 2'b00;
            lat_signed <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                BusErr   <= 1'b0;
                tout_cnt <= '0;
                if (!trap) begin
                    bus_we     <= MemWrite;
                    bus_addr   <= {ALUResult[31:2], 2'b00};
                    bus_be     <= st_be;
                    bus_wdata  <= st_wdata;
                    lat_size   <= MemSize;
                    lat_off    <= ALUResult[1:0];
                    lat_signed <= MemSigned;
                end
            end
            if (state == REQ) begin
                tout_cnt <= tout_cnt + 1'b1;
                if (bus_ack) begin
                    if (!bus_we) DataOut <= ld_ext;
                end else if (timeout) begin
                    BusErr  <= 1'b1;
                    DataOut <= BUS_ERR_DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed accesses followed by
// randomized loads/stores compared against a behavioural lane/latency model.
module tb_load_store_unit;

    localparam int TIMEOUT = 16;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite, MemSigned;
    logic [1:0]  MemSize;
    logic [31:0] ALUResult, WriteData;
    logic        Stall, BusErr, MisAlign;
    logic [31:0] DataOut;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_dout;
    logic        exp_buserr, exp_misalign;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemSize   (MemSize),
        .MemSigned (MemSigned),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .Stall     (Stall),
        .DataOut   (DataOut),
        .BusErr    (BusErr),
        .MisAlign  (MisAlign),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] modelBe(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'(1 << off);
            2'b01:   return off[1] ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] modelWdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   return (wd & 32'hFF) * 32'h0101_0101;
            2'b01:   return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic [1:0] off,
                                              input logic sgn, input logic [31:0] rd);
        logic [31:0] v;
        int          sh;
        case (size)
            2'b00: begin
                sh = 8 * off;
                v  = (rd >> sh) & 32'hFF;
                if (sgn && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                sh = off[1] ? 16 : 0;
                v  = (rd >> sh) & 32'hFFFF;
                if (sgn && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic bit modelTrap(input logic [1:0] size, input logic [1:0] off);
        bit mis;
        mis = ((size == 2'b01) && off[0]) || ((size >= 2'b10) && (off != 2'b00));
        return mis && TRAP_EN;
    endfunction

    // One instruction: IDLE request cycle, REQ cycles until ack/timeout, DONE check.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rdat,
                                 input int ack_lat);
        bit   trap, tmo;
        int   stall_cnt, exp_stall, cyc;
        logic [1:0] off;
        off = addr[1:0];
        @(negedge clk);
        MemRead   = rd;
        MemWrite  = wr;
        MemSize   = size;
        MemSigned = sgn;
        ALUResult = addr;
        WriteData = wd;
        bus_ack   = 1'b0;
        trap      = modelTrap(size, off);
        #1;
        checkOutput("stall_idle", 32'(Stall), 32'd1);
        stall_cnt = 1;
        @(negedge clk);
        if (trap) begin
            exp_misalign = 1'b1;
            exp_buserr   = 1'b0;
            checkOutput("trap_noreq", 32'(bus_req), 32'd0);
            checkOutput("trap_stall", 32'(Stall), 32'd0);
        end else begin
            checkOutput("req", 32'(bus_req), 32'd1);
            checkOutput("we", 32'(bus_we), 32'(wr));
            checkOutput("addr", bus_addr, {addr[31:2], 2'b00});
            checkOutput("be", 32'(bus_be), 32'(modelBe(size, off)));
            if (wr) checkOutput("wdata", bus_wdata, modelWdata(size, wd));
            cyc = 0;
            while (Stall && cyc < 40) begin
                stall_cnt++;
                checkOutput("addr_hold", bus_addr, {addr[31:2], 2'b00});
                if (cyc == ack_lat) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rdat;
                end else begin
                    bus_ack   = 1'b0;
                    bus_rdata = $urandom;
                end
                @(negedge clk);
                bus_ack = 1'b0;
                cyc++;
            end
            tmo       = !(ack_lat >= 0 && ack_lat < TIMEOUT);
            exp_stall = tmo ? 1 + TIMEOUT : 2 + ack_lat;
            if (tmo) begin
                exp_dout   = 32'h0;
                exp_buserr = 1'b1;
            end else begin
                exp_buserr = 1'b0;
                if (!wr) exp_dout = modelLoad(size, off, sgn, rdat);
            end
            exp_misalign = 1'b0;
            checkOutput("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
            checkOutput("done_req", 32'(bus_req), 32'd0);
        end
        checkOutput("dout", DataOut, exp_dout);
        checkOutput("buserr", 32'(BusErr), 32'(exp_buserr));
        checkOutput("misalign", 32'(MisAlign), 32'(exp_misalign));
    endtask

    task automatic idleCycle();
        @(negedge clk);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        #1;
        checkOutput("stall_free", 32'(Stall), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_stall"}, 32'(Stall), 32'd0);
        checkOutput({tag, "_dout"}, DataOut, 32'd0);
        checkOutput({tag, "_buserr"}, 32'(BusErr), 32'd0);
        checkOutput({tag, "_misalign"}, 32'(MisAlign), 32'd0);
        checkOutput({tag, "_req"}, 32'(bus_req), 32'd0);
        checkOutput({tag, "_we"}, 32'(bus_we), 32'd0);
        checkOutput({tag, "_addr"}, bus_addr, 32'd0);
        checkOutput({tag, "_be"}, 32'(bus_be), 32'd0);
        checkOutput({tag, "_wdata"}, bus_wdata, 32'd0);
    endtask

    // Abort a load two cycles into REQ with an asynchronous reset pulse.
    task automatic resetMidReq();
        @(negedge clk);
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        MemSize   = 2'b10;
        MemSigned = 1'b0;
        ALUResult = 32'h0000_0300;
        WriteData = 32'h5555_AAAA;
        @(negedge clk);
        checkOutput("rst_pre_req", 32'(bus_req), 32'd1);
        @(negedge clk);
        #2;
        MemRead = 1'b0;
        rst_n   = 1'b0;
        #1;
        checkResetValues("rst_mid");
        #1;
        rst_n        = 1'b1;
        exp_dout     = 32'h0;
        exp_buserr   = 1'b0;
        exp_misalign = 1'b0;
    endtask

    initial begin
        bit         rd, wr;
        logic [1:0] size;
        int         lat;
        rst_n        = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemSize      = 2'b00;
        MemSigned    = 1'b0;
        ALUResult    = '0;
        WriteData    = '0;
        bus_rdata    = '0;
        bus_ack      = 1'b0;
        exp_dout     = 32'h0;
        exp_buserr   = 1'b0;
        exp_misalign = 1'b0;
        #12;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_BABE, 0);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0, 32'h8011_2233, 0);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0, 32'h8011_2233, 1);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h0000_BEEF, 32'h0, 3);
        applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_0040, 32'h1234_5678, 32'hDEAD_BEEF, 1);
        idleCycle();
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0, 32'h0, -1);
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0, 32'h8001_7FFF, 2);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'h0BAD_F00D, TIMEOUT - 1);
        resetMidReq();
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'h1357_9BDF, 0);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 32'hA5A5_5A5A, 0);

        for (int i = 0; i < 80; i++) begin
            rd   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            size = 2'($urandom_range(0, 3));
            if (rd && !wr && $urandom_range(0, 9) == 0) lat = -1;
            else lat = $urandom_range(0, 5);
            applyStimulus(rd, wr, size, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, lat);
            if ($urandom_range(0, 3) == 0) idleCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage of the 32-bit CPU. Sits between the EX-stage address/store-data outputs and the writeback select mux.
- Converts MemRead/MemWrite requests into a handshaked, word-aligned bus transaction with byte enables.
- Stalls the core until the transaction completes.
- Returns sign- or zero-extended load data on DataOut, which the writeback select mux consumes.

Parameters:
- TIMEOUT_CYCLES, 16: cycles in REQ without bus_ack before the access is aborted with BusErr.
- CNT_W, 5: timeout counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- MemRead  in  1  load request from EX.
- MemWrite  in  1  store request from EX.
- MemSize  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- MemSigned  in  1  1 = sign-extend loads, 0 = zero-extend.
- ALUResult  in  32  byte address.
- WriteData  in  32  store data, right-justified.
- Stall  out  1  holds PC and pipeline registers.
- DataOut  out  32  extended load data, registered.
- BusErr  out  1  timeout flag.
- MisAlign  out  1  misalignment flag (only active with the optional feature).
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  ALUResult with [1:0] forced to 00.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read data, valid with bus_ack.
- bus_ack  in  1  single-cycle completion.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state IDLE; Stall 0; DataOut 0; BusErr 0; MisAlign 0; bus_req 0; bus_we 0; bus_addr 0; bus_be 0; bus_wdata 0; timeout counter 0.
- States: IDLE, REQ, DONE.
- IDLE:
  - If MemWrite or MemRead: latch the bus fields, go to REQ.
  - Stall is asserted combinationally in this same cycle.
  - BusErr and MisAlign clear when a new request is accepted.
- REQ:
  - bus_req = 1. All bus fields stay stable until bus_ack.
  - Stall = 1.
  - Counter increments every cycle.
  - On bus_ack: a load registers the extracted data into DataOut; go to DONE.
  - Counter reaching TIMEOUT_CYCLES with no ack: bus_req drops, BusErr = 1 (sticky until the next accepted request), DataOut = 0, go to DONE.
- DONE:
  - Stall = 0 for exactly one cycle, so the core advances and writeback samples DataOut. Then go to IDLE.
  - The requests seen in DONE belong to the same instruction and are ignored.
- Total latency: a load with ack in its first REQ cycle stalls 2 cycles; DataOut is valid in DONE.
- DataOut holds its value until the next load completes. Stores never modify it.
- MemRead and MemWrite both high: write wins; the read is dropped.
- Byte lanes, with off = ALUResult[1:0]:
  - Byte: be = 0001 << off; wdata = byte replicated x4.
  - Half: be = off[1] ? 1100 : 0011; wdata = half replicated x2.
  - Word: be = 1111.
- Load extract uses the same lane selection, then extends to 32 bits according to MemSigned. Word loads pass through unchanged.
- Misalignment without the macro: half with off[0]=1, or word with off≠0, is silently aligned down by ignoring the low bits.
- rst_n asserted during REQ: immediate return to IDLE, bus_req = 0, no DataOut update.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- When defined:
  - A misaligned access issues no bus transaction. It goes IDLE -> DONE.
  - MisAlign = 1 (sticky until the next accepted request).
  - DataOut is unchanged.
  - Stall is high only in the IDLE cycle.
- When undefined: silent alignment as above; MisAlign is tied to 0.

Decomposition:
- Shared cpu_pkg holds:
  - MemSize encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - LSU state enum: IDLE, REQ, DONE.
  - BUS_ERR_DATA = 32'h0.
- One sub-module, lsu_lane_align (combinational), covers store lane replication with be generation, and load extract with extension. The FSM and counter stay in the top block.

Test Plan:
- Word load, addr 0x100, bus_rdata 0xCAFEBABE, ack on the 1st REQ cycle -> bus_addr 0x100, be 1111; Stall high 2 cycles; DataOut = 0xCAFEBABE in DONE.
- Signed byte load, addr 0x203, rdata 0x80112233 -> be 1000; DataOut 0xFFFFFF80. Same access with MemSigned=0 -> 0x00000080.
- Half store, addr 0x06, WriteData 0x0000BEEF, ack after 3 cycles -> bus_we 1; be 1100; wdata 0xBEEFBEEF; Stall 5 cycles; DataOut unchanged.
- Load with no ack, TIMEOUT_CYCLES=16 -> bus_req drops after 16 REQ cycles; BusErr = 1; DataOut = 0; Stall released one cycle later.
- rst_n pulsed low mid-REQ -> outputs return asynchronously to reset values; the next load completes normally.
- With LSU_MISALIGN_TRAP_EN, word load at 0x102 -> no bus_req; MisAlign = 1; Stall 1 cycle; DataOut unchanged.
